// File: rtl/mem_decoder_pkg.sv
// -----------------------------------------------------------------------------
// mem_decoder_pkg
//   Shared types and address-map constants for the peripheral memory path.
//   - mem_in_type / mem_out_type : request and response bundles seen by the
//     arbiter and every peripheral, with their idle values.
//   - dec_state_type             : decoder FSM state encoding.
//   - slave_sel_type             : index of the selected slave (up to 16).
//   - *_base_addr / *_mask_addr  : default peripheral windows, packed into the
//     decoder's default BASE/MASK arrays (index 0 = rom ... 5 = uart_tx).
//   - mem_decoder_timeout        : default watchdog limit in cycles.
// -----------------------------------------------------------------------------
package mem_decoder_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
  } mem_out_type;

  localparam mem_in_type  init_mem_in  = '0;
  localparam mem_out_type init_mem_out = '0;

  typedef logic [1:0] dec_state_type;

  localparam dec_state_type ST_IDLE  = 2'd0;
  localparam dec_state_type ST_BUSY  = 2'd1;
  localparam dec_state_type ST_ERR   = 2'd2;
  localparam dec_state_type ST_DRAIN = 2'd3;

  typedef logic [3:0] slave_sel_type;

  localparam logic [31:0] rom_base_addr     = 32'h0000_0000;
  localparam logic [31:0] rom_mask_addr     = 32'h0000_FFFF;
  localparam logic [31:0] ram_base_addr     = 32'h8000_0000;
  localparam logic [31:0] ram_mask_addr     = 32'h0FFF_FFFF;
  localparam logic [31:0] spi_base_addr     = 32'h2000_0000;
  localparam logic [31:0] spi_mask_addr     = 32'h0000_0FFF;
  localparam logic [31:0] clint_base_addr   = 32'h0200_0000;
  localparam logic [31:0] clint_mask_addr   = 32'h0000_FFFF;
  localparam logic [31:0] uart_rx_base_addr = 32'h1000_0000;
  localparam logic [31:0] uart_rx_mask_addr = 32'h0000_0003;
  localparam logic [31:0] uart_tx_base_addr = 32'h1000_0004;
  localparam logic [31:0] uart_tx_mask_addr = 32'h0000_0003;

  // Packed arrays list the highest index first, so rom ends up at [0].
  localparam logic [5:0][31:0] mem_decoder_base_addr = {
    uart_tx_base_addr, uart_rx_base_addr, clint_base_addr,
    spi_base_addr, ram_base_addr, rom_base_addr
  };
  localparam logic [5:0][31:0] mem_decoder_mask_addr = {
    uart_tx_mask_addr, uart_rx_mask_addr, clint_mask_addr,
    spi_mask_addr, ram_mask_addr, rom_mask_addr
  };

  localparam int mem_decoder_timeout = 1024;

  // An address falls in a window when the bits outside the offset mask
  // equal the window base.
  function automatic logic addr_hits(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (addr & ~mask) == base;
  endfunction

endpackage

// File: rtl/mem_decoder_addr_match.sv
// -----------------------------------------------------------------------------
// mem_decoder_addr_match
//   Priority address matcher: compares one address against every slave
//   window and returns the lowest matching slave index.
//   Ports:
//     addr   in  32  address to decode
//     hit    out 1   some window matched
//     index  out 4   lowest matching slave index (0 when no hit)
// -----------------------------------------------------------------------------
module mem_decoder_addr_match
  import mem_decoder_pkg::*;
#(
  parameter int                            NUM_SLAVES = 6,
  parameter logic [NUM_SLAVES-1:0][31:0]   BASE_ADDR  = mem_decoder_base_addr,
  parameter logic [NUM_SLAVES-1:0][31:0]   MASK_ADDR  = mem_decoder_mask_addr
) (
  input  logic [31:0]   addr,
  output logic          hit,
  output slave_sel_type index
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    // Scanning from the top down lets the lowest matching index win.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (addr_hits(addr, BASE_ADDR[i], MASK_ADDR[i])) begin
        hit   = 1'b1;
        index = slave_sel_type'(i);
      end
    end
  end

endmodule

// File: rtl/mem_decoder.sv
// -----------------------------------------------------------------------------
// mem_decoder
//   Single-master to NUM_SLAVES memory-bus decoder with one outstanding
//   request. Requests are forwarded to the matching slave in the cycle they
//   arrive, with the address rebased to the window offset; the slave's
//   response is passed straight back. Unmapped requests receive a registered
//   error response one cycle later.
//
//   Optional feature (macro MEM_DECODER_TIMEOUT_EN): a watchdog answers a
//   hung slave with an error after TIMEOUT_CYCLES, then drains the slave's
//   late response while holding one new request in a pending buffer.
//
//   Ports:
//     clock        in   1                system clock
//     reset        in   1                asynchronous, active-low reset
//     master_in    in   mem_in_type      request from arbiter (1-cycle valid)
//     master_out   out  mem_out_type     response to arbiter
//     slave_in     out  mem_in_type [N]  per-slave request (offset address)
//     slave_out    in   mem_out_type [N] per-slave response
//     decode_err   out  1                pulse when an unmapped access is answered
//     timeout_err  out  1                pulse when the watchdog fires
// -----------------------------------------------------------------------------
module mem_decoder
  import mem_decoder_pkg::*;
#(
  parameter int                          NUM_SLAVES     = 6,
  parameter logic [NUM_SLAVES-1:0][31:0] BASE_ADDR      = mem_decoder_base_addr,
  parameter logic [NUM_SLAVES-1:0][31:0] MASK_ADDR      = mem_decoder_mask_addr,
  parameter int                          TIMEOUT_CYCLES = mem_decoder_timeout
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  master_in,
  output mem_out_type master_out,
  output mem_in_type  slave_in  [NUM_SLAVES],
  input  mem_out_type slave_out [NUM_SLAVES],
  output logic        decode_err,
  output logic        timeout_err
);

  localparam mem_out_type err_rsp = '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: 32'h0};

  dec_state_type state_q, state_d;
  slave_sel_type sel_q, sel_d;
  mem_in_type    req;
  logic          req_hit;
  slave_sel_type req_idx;
  logic          issue;
  mem_out_type   sel_rsp;

`ifdef MEM_DECODER_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        cnt_hit;
  logic        pend_valid_q;
  mem_in_type  pend_q;

  assign cnt_hit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // A request buffered during DRAIN takes the place of master_in once the
  // FSM is back in IDLE. The valid is gated by reset so nothing is forwarded
  // while reset is held.
  always_comb begin
    req           = pend_valid_q ? pend_q : master_in;
    req.mem_valid = req.mem_valid & reset;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;

  always_comb begin
    req           = master_in;
    req.mem_valid = master_in.mem_valid & reset;
  end
`endif

  mem_decoder_addr_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .MASK_ADDR  (MASK_ADDR)
  ) u_addr_match (
    .addr  (req.mem_addr),
    .hit   (req_hit),
    .index (req_idx)
  );

  // Response of the slave currently owning the transaction.
  always_comb begin
    sel_rsp = init_mem_out;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == slave_sel_type'(i)) sel_rsp = slave_out[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    issue       = 1'b0;
    master_out  = init_mem_out;
    decode_err  = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req.mem_valid) begin
          if (req_hit) begin
            issue   = 1'b1;
            sel_d   = req_idx;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        master_out = err_rsp;
        decode_err = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_BUSY: begin
        // Valids arriving here violate the protocol and are simply dropped.
        if (sel_rsp.mem_ready) begin
          master_out = sel_rsp;
          state_d    = ST_IDLE;
        end
`ifdef MEM_DECODER_TIMEOUT_EN
        else if (cnt_hit) begin
          master_out  = err_rsp;
          timeout_err = 1'b1;
          state_d     = ST_DRAIN;
        end
`endif
      end
`ifdef MEM_DECODER_TIMEOUT_EN
      ST_DRAIN: begin
        // The late response is swallowed; a second bounded count stops a
        // slave that never answers from wedging the bus.
        if (sel_rsp.mem_ready || cnt_hit) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slave_in[i] = init_mem_in;
      if (issue && (req_idx == slave_sel_type'(i))) begin
        slave_in[i]          = req;
        slave_in[i].mem_addr = req.mem_addr - BASE_ADDR[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

`ifdef MEM_DECODER_TIMEOUT_EN
  // The counter restarts on every state change, so it measures time spent
  // in the current BUSY or DRAIN visit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if ((state_q == ST_BUSY) || (state_q == ST_DRAIN)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // NOTE: the one-entry pending payload is reset along with its valid flag;
  // it is a single register, not a RAM, so the reset costs nothing and keeps
  // the buffer free of X after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_valid_q <= 1'b0;
      pend_q       <= init_mem_in;
    end else if ((state_q == ST_DRAIN) && master_in.mem_valid && !pend_valid_q) begin
      pend_valid_q <= 1'b1;
      pend_q       <= master_in;
    end else if (state_q == ST_IDLE) begin
      pend_valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_decoder.sv
// -----------------------------------------------------------------------------
// tb_mem_decoder
//   Directed self-checking bench for mem_decoder. Inputs change 1 ns after
//   the rising edge and outputs are checked 1 ns later, mid-cycle. The
//   watchdog scenario runs only when MEM_DECODER_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_decoder;
  import mem_decoder_pkg::*;

  logic        clock;
  logic        reset;
  mem_in_type  master_in;
  mem_out_type master_out;
  mem_in_type  slave_in  [6];
  mem_out_type slave_out [6];
  logic        decode_err;
  logic        timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  mem_decoder #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .master_in   (master_in),
    .master_out  (master_out),
    .slave_in    (slave_in),
    .slave_out   (slave_out),
    .decode_err  (decode_err),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [5:0] slave_valids();
    logic [5:0] v;
    for (int i = 0; i < 6; i++) v[i] = slave_in[i].mem_valid;
    return v;
  endfunction

  task automatic send(input logic [31:0] addr);
    master_in           = init_mem_in;
    master_in.mem_valid = 1'b1;
    master_in.mem_addr  = addr;
    master_in.mem_wdata = 32'hCAFE_0000 | addr[15:0];
    master_in.mem_wstrb = 4'hF;
  endtask

  task automatic respond(input int idx, input logic [31:0] rdata);
    slave_out[idx].mem_ready = 1'b1;
    slave_out[idx].mem_error = 1'b0;
    slave_out[idx].mem_rdata = rdata;
  endtask

  task automatic idle_inputs();
    master_in = init_mem_in;
    for (int i = 0; i < 6; i++) slave_out[i] = init_mem_out;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();

    // Reset state.
    step();
    step();
    check("rst_ready", 32'(master_out.mem_ready), 32'h0);
    check("rst_rdata", master_out.mem_rdata, 32'h0);
    check("rst_slave_valid", 32'(slave_valids()), 32'h0);
    check("rst_decode_err", 32'(decode_err), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    reset = 1'b1;

    // RAM read: forwarded same cycle with offset 0x10, answered 3 cycles later.
    step();
    send(32'h8000_0010);
    settle();
    check("ram_fwd_valid", 32'(slave_valids()), 32'h02);
    check("ram_fwd_addr", slave_in[1].mem_addr, 32'h0000_0010);
    check("ram_fwd_wdata", slave_in[1].mem_wdata, 32'hCAFE_0010);
    check("ram_req_ready", 32'(master_out.mem_ready), 32'h0);
    step();
    master_in = init_mem_in;
    step();
    step();
    respond(1, 32'hDEAD_BEEF);
    settle();
    check("ram_rsp_ready", 32'(master_out.mem_ready), 32'h1);
    check("ram_rsp_rdata", master_out.mem_rdata, 32'hDEAD_BEEF);
    check("ram_rsp_error", 32'(master_out.mem_error), 32'h0);
    step();
    slave_out[1] = init_mem_out;

    // Unmapped access: nothing forwarded, error response one cycle later.
    send(32'hF000_0000);
    settle();
    check("unmap_no_fwd", 32'(slave_valids()), 32'h0);
    check("unmap_ready_early", 32'(master_out.mem_ready), 32'h0);
    step();
    master_in = init_mem_in;
    settle();
    check("unmap_ready", 32'(master_out.mem_ready), 32'h1);
    check("unmap_error", 32'(master_out.mem_error), 32'h1);
    check("unmap_rdata", master_out.mem_rdata, 32'h0);
    check("unmap_decode_err", 32'(decode_err), 32'h1);
    step();
    check("unmap_err_pulse_end", 32'(decode_err), 32'h0);
    check("unmap_ready_end", 32'(master_out.mem_ready), 32'h0);

    // SPI busy while uart_tx raises a stray ready.
    send(32'h2000_0040);
    settle();
    check("spi_fwd_valid", 32'(slave_valids()), 32'h04);
    check("spi_fwd_addr", slave_in[2].mem_addr, 32'h0000_0040);
    step();
    master_in = init_mem_in;
    respond(5, 32'h0000_0055);
    settle();
    check("stray_ready", 32'(master_out.mem_ready), 32'h0);
    check("stray_rdata", master_out.mem_rdata, 32'h0);
    step();
    slave_out[5] = init_mem_out;
    respond(2, 32'h0000_00A5);
    settle();
    check("spi_rsp_ready", 32'(master_out.mem_ready), 32'h1);
    check("spi_rsp_rdata", master_out.mem_rdata, 32'h0000_00A5);
    step();
    slave_out[2] = init_mem_out;

    // Back-to-back: rom answered at cycle 2, clint request at cycle 3.
    send(32'h0000_0123);
    settle();
    check("rom_fwd_addr", slave_in[0].mem_addr, 32'h0000_0123);
    step();
    master_in = init_mem_in;
    step();
    respond(0, 32'h1111_1111);
    settle();
    check("rom_rsp_rdata", master_out.mem_rdata, 32'h1111_1111);
    step();
    slave_out[0] = init_mem_out;
    send(32'h0200_4000);
    settle();
    check("clint_fwd_valid", 32'(slave_valids()), 32'h08);
    check("clint_fwd_addr", slave_in[3].mem_addr, 32'h0000_4000);
    step();
    // A valid while BUSY is a protocol violation and must be dropped.
    send(32'h8000_0000);
    settle();
    check("busy_valid_dropped", 32'(slave_valids()), 32'h0);
    step();
    master_in = init_mem_in;
    respond(3, 32'h2222_2222);
    settle();
    check("clint_rsp_rdata", master_out.mem_rdata, 32'h2222_2222);
    step();
    slave_out[3] = init_mem_out;

    // Window edges: last uart_rx byte and first uart_tx byte.
    send(32'h1000_0003);
    settle();
    check("uart_rx_edge_sel", 32'(slave_valids()), 32'h10);
    check("uart_rx_edge_addr", slave_in[4].mem_addr, 32'h0000_0003);
    step();
    master_in = init_mem_in;
    respond(4, 32'h0000_0044);
    settle();
    check("uart_rx_rsp", master_out.mem_rdata, 32'h0000_0044);
    step();
    slave_out[4] = init_mem_out;
    send(32'h1000_0004);
    settle();
    check("uart_tx_edge_sel", 32'(slave_valids()), 32'h20);
    check("uart_tx_edge_addr", slave_in[5].mem_addr, 32'h0000_0000);
    step();
    master_in = init_mem_in;
    respond(5, 32'h0000_0066);
    settle();
    check("uart_tx_rsp", master_out.mem_rdata, 32'h0000_0066);
    step();
    slave_out[5] = init_mem_out;
    // One past uart_tx and one past the rom window are both unmapped.
    send(32'h0001_0000);
    settle();
    check("rom_past_end_no_fwd", 32'(slave_valids()), 32'h0);
    step();
    master_in = init_mem_in;
    settle();
    check("rom_past_end_err", 32'(decode_err), 32'h1);
    step();

    // Asynchronous reset in the middle of a BUSY transaction.
    send(32'h8000_0100);
    step();
    master_in = init_mem_in;
    respond(1, 32'h9999_9999);
    settle();
    check("pre_reset_passthru", 32'(master_out.mem_ready), 32'h1);
    reset = 1'b0;
    settle();
    check("async_rst_ready", 32'(master_out.mem_ready), 32'h0);
    check("async_rst_rdata", master_out.mem_rdata, 32'h0);
    check("async_rst_slave", 32'(slave_valids()), 32'h0);
    step();
    slave_out[1] = init_mem_out;
    reset = 1'b1;
    step();
    send(32'h0000_0200);
    settle();
    check("post_rst_fwd_addr", slave_in[0].mem_addr, 32'h0000_0200);
    step();
    master_in = init_mem_in;
    respond(0, 32'h4242_4242);
    settle();
    check("post_rst_rsp", master_out.mem_rdata, 32'h4242_4242);
    step();
    slave_out[0] = init_mem_out;

`ifdef MEM_DECODER_TIMEOUT_EN
    // Watchdog: spi stays silent, timeout answered at cycle 8.
    send(32'h2000_0000);
    step();
    master_in = init_mem_in;
    for (int c = 1; c < 8; c++) step();
    check("wd_not_early", 32'(master_out.mem_ready), 32'h1);
    check("wd_error", 32'(master_out.mem_error), 32'h1);
    check("wd_rdata", master_out.mem_rdata, 32'h0);
    check("wd_timeout_err", 32'(timeout_err), 32'h1);
    step();
    // DRAIN: rom request is held, not forwarded.
    send(32'h0000_0008);
    settle();
    check("drain_held", 32'(slave_valids()), 32'h0);
    check("drain_err_pulse_end", 32'(timeout_err), 32'h0);
    step();
    master_in = init_mem_in;
    respond(2, 32'h0000_0077);
    settle();
    check("drain_swallow", 32'(master_out.mem_ready), 32'h0);
    step();
    slave_out[2] = init_mem_out;
    settle();
    check("pend_issue_sel", 32'(slave_valids()), 32'h01);
    check("pend_issue_addr", slave_in[0].mem_addr, 32'h0000_0008);
    step();
    respond(0, 32'h3333_3333);
    settle();
    check("pend_rsp_rdata", master_out.mem_rdata, 32'h3333_3333);
    check("pend_rsp_error", 32'(master_out.mem_error), 32'h0);
    step();
    slave_out[0] = init_mem_out;
`else
    // Without the watchdog a silent slave keeps the decoder waiting.
    send(32'h2000_0000);
    step();
    master_in = init_mem_in;
    for (int c = 1; c < 12; c++) step();
    check("no_wd_ready", 32'(master_out.mem_ready), 32'h0);
    check("no_wd_timeout_err", 32'(timeout_err), 32'h0);
    respond(2, 32'h0000_0777);
    settle();
    check("no_wd_late_rsp", master_out.mem_rdata, 32'h0000_0777);
    step();
    slave_out[2] = init_mem_out;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
